reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised multi-port register file, successor to the fixed 16x16 register file. Provides 2 combinational read ports and 2 synchronous write ports with fixed priority. Adds optional hardwired zero register, optional write-to-read bypass, and a per-register pending (scoreboard) bit for the datapath issue logic. Sits between the decode stage (reads/reserves) and the writeback stage (writes).

Parameters:
WIDTH, 16, data width in bits
DEPTH, 16, number of registers (2..256; need not be a power of two)
ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes/reserves
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
ADDR_W, $clog2(DEPTH), derived address width (localparam, not overridable)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-low
Re1  in  ADDR_W  read address, port A
Re2  in  ADDR_W  read address, port B
D1  out  WIDTH  read data, port A
D2  out  WIDTH  read data, port B
P1  out  1  pending flag for Re1
P2  out  1  pending flag for Re2
We0  in  1  write enable, port 0
W0  in  ADDR_W  write address, port 0
Da0  in  WIDTH  write data, port 0
We1  in  1  write enable, port 1 (priority over port 0)
W1  in  ADDR_W  write address, port 1
Da1  in  WIDTH  write data, port 1
Rsv  in  1  reserve enable (mark register in flight)
RsvA  in  ADDR_W  reserve address

Behaviour:
- Reset (Rst=0, async, no clock needed): N[k] = k truncated to WIDTH for all k (N[0]=0); all pending bits cleared. Outputs settle combinationally: D1=Re1, D2=Re2 (index values), P1=P2=0.
- Writes: on rising Clk with Rst=1; We0 writes Da0 to N[W0], We1 writes Da1 to N[W1]. Same address on both: port 1 value lands. Address >= DEPTH: write dropped. ZERO_REG=1 and address 0: write dropped.
- Reads: combinational, zero latency. Address >= DEPTH returns 0, pending 0. ZERO_REG=1 and address 0 returns 0, pending 0.
- Bypass (BYPASS=1): if a valid write (enabled, in range, not to zero reg) targets the read address this cycle, D shows the write data (port 1 over port 0) and P reads 0. BYPASS=0: read shows stored value until after the edge.
- Pending: Rsv sets pending[RsvA] on the edge; any valid write to an address clears its bit on the edge. Reserve and write to same address in same cycle: bit ends set (new producer wins); data still written. Reserve of an already-pending register: stays set. Reserve out of range or of zero reg (ZERO_REG=1): ignored.
- Reset mid-operation: immediately overrides, re-initialises array and pending bits; writes/reserves on that edge discarded.
- No blocking assignments to array state; all writes resolve in one cycle; no X propagation from out-of-range addresses.

Decomposition:
- Shared package regfile_pkg: default WIDTH/DEPTH constants and the reset-init function (index-to-value).
- One sub-module natural: rf_scoreboard (DEPTH pending bits, set/clear/priority logic, two lookup ports). Storage, write priority and bypass muxes stay in reg_file_sb.

Test Plan:
- Reset: pulse Rst=0 between clocks -> without edge D1=5 for Re1=5, D2=15 for Re2=15, P1=P2=0.
- Dual write collision: We0=We1=1, W0=W1=3, Da0=16'hAAAA, Da1=16'h5555 -> after edge Re1=3 gives 16'h5555; same cycle with BYPASS=1 D1=16'h5555.
- Bypass off: BYPASS=0, write 16'h1234 to reg 7 -> D1(Re1=7) stays 7 until the edge, then 16'h1234.
- Scoreboard: Rsv to reg 4 -> P1=1 after edge; write reg 4 with 16'h00FF -> P1=0, D1=16'h00FF; Rsv and write reg 4 same cycle -> P1=1 after edge.
- Zero register: ZERO_REG=1, write 16'hFFFF and Rsv to reg 0 -> D1=0, P1=0; DEPTH=12, write reg 13 -> no register changes, read of 13 returns 0.
- Async reset mid-traffic: Rst low between edges while reg 2 pending and holds 16'hBEEF -> immediately D1(Re1=2)=2, P1=0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and reset-image helper for the scoreboarded register file.
package regfile_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  // Register k comes out of reset holding its own index; callers truncate to WIDTH.
  function automatic logic [31:0] init_val(input int idx);
    return 32'(idx);
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback facing bus of the register file: two read ports, two write ports, one reserve port.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] Re1, Re2;
  logic [WIDTH-1:0]  D1, D2;
  logic              P1, P2;
  logic              We0, We1;
  logic [ADDR_W-1:0] W0, W1;
  logic [WIDTH-1:0]  Da0, Da1;
  logic              Rsv;
  logic [ADDR_W-1:0] RsvA;

  modport master (output Re1, Re2, We0, W0, Da0, We1, W1, Da1, Rsv, RsvA,
                  input  D1, D2, P1, P2);
  modport slave  (input  Re1, Re2, We0, W0, Da0, We1, W1, Da1, Rsv, RsvA,
                  output D1, D2, P1, P2);
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register in-flight bits: reserve sets, writes clear, reserve wins on a same-edge collision.
module rf_scoreboard #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr0_en,
  input  logic [ADDR_W-1:0]      clr0_addr,
  input  logic                   clr1_en,
  input  logic [ADDR_W-1:0]      clr1_addr,
  input  logic [1:0][ADDR_W-1:0] look_addr,
  output logic [1:0]             look_pend
);
  logic [DEPTH-1:0] pend;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (set_en && set_addr == ADDR_W'(k))
          pend[k] <= 1'b1;
        else if ((clr0_en && clr0_addr == ADDR_W'(k)) || (clr1_en && clr1_addr == ADDR_W'(k)))
          pend[k] <= 1'b0;
      end
    end
  end

  // Out-of-range lookups fall through every compare and read as not pending.
  always_comb begin
    look_pend = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < DEPTH; k++)
        if (look_addr[p] == ADDR_W'(k)) look_pend[p] = pend[k];
  end
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised 2R/2W register file with optional zero register, write bypass and pending scoreboard.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic          Clk,
  input logic          Rst,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][WIDTH-1:0]  rdat;
  logic [1:0]             rhit, rpend, sb_pend;
  logic                   wv0, wv1, rsv_ok;

  function automatic logic in_use(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // Qualified with Rst so nothing is forwarded or recorded while held in reset.
  assign wv0    = Rst & bus.We0 & in_use(bus.W0);
  assign wv1    = Rst & bus.We1 & in_use(bus.W1);
  assign rsv_ok = Rst & bus.Rsv & in_use(bus.RsvA);
  assign ra     = {bus.Re2, bus.Re1};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= WIDTH'(init_val(k));
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wv1 && bus.W1 == ADDR_W'(k))      mem[k] <= bus.Da1;
        else if (wv0 && bus.W0 == ADDR_W'(k)) mem[k] <= bus.Da0;
      end
    end
  end

  always_comb begin
    rdat  = '0;
    rhit  = '0;
    rpend = '0;
    for (int p = 0; p < 2; p++) begin
      if (in_use(ra[p])) begin
        for (int k = 0; k < DEPTH; k++)
          if (ra[p] == ADDR_W'(k)) rdat[p] = mem[k];
        if (BYPASS != 0 && wv1 && bus.W1 == ra[p]) begin
          rdat[p] = bus.Da1;
          rhit[p] = 1'b1;
        end else if (BYPASS != 0 && wv0 && bus.W0 == ra[p]) begin
          rdat[p] = bus.Da0;
          rhit[p] = 1'b1;
        end
        // A forwarded value is already the produced result, so it is not in flight.
        rpend[p] = sb_pend[p] & ~rhit[p];
      end
    end
  end

  assign bus.D1 = rdat[0];
  assign bus.D2 = rdat[1];
  assign bus.P1 = rpend[0];
  assign bus.P2 = rpend[1];

  rf_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_sb (
    .Clk       (Clk),
    .Rst       (Rst),
    .set_en    (rsv_ok),
    .set_addr  (bus.RsvA),
    .clr0_en   (wv0),
    .clr0_addr (bus.W0),
    .clr1_en   (wv1),
    .clr1_addr (bus.W1),
    .look_addr (ra),
    .look_pend (sb_pend)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default, no-bypass and zero-reg/DEPTH=12 instances checked via a result queue.
module tb_reg_file_sb;
  typedef struct packed {
    logic we0; logic [3:0] w0; logic [15:0] da0;
    logic we1; logic [3:0] w1; logic [15:0] da1;
    logic rsv; logic [3:0] rsva;
    logic [3:0] re1; logic [3:0] re2;
  } drv_t;
  typedef struct { drv_t in; logic [15:0] d1; logic p1; logic [15:0] d2; logic p2; } vec_t;
  typedef struct { string name; int inst; int port; logic [15:0] d; logic p; } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  drv_t drv [3];
  exp_t sbq [$];
  vec_t tbl [15];
  int   n_chk = 0;
  int   n_fail = 0;

  reg_file_sb_if #(.WIDTH(16), .DEPTH(16)) if_d ();
  reg_file_sb_if #(.WIDTH(16), .DEPTH(16)) if_n ();
  reg_file_sb_if #(.WIDTH(16), .DEPTH(12)) if_z ();

  reg_file_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) u_d (.Clk(Clk), .Rst(Rst), .bus(if_d));
  reg_file_sb #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) u_n (.Clk(Clk), .Rst(Rst), .bus(if_n));
  reg_file_sb #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1), .BYPASS(1)) u_z (.Clk(Clk), .Rst(Rst), .bus(if_z));

  assign {if_d.We0, if_d.W0, if_d.Da0, if_d.We1, if_d.W1, if_d.Da1, if_d.Rsv, if_d.RsvA, if_d.Re1, if_d.Re2} = drv[0];
  assign {if_n.We0, if_n.W0, if_n.Da0, if_n.We1, if_n.W1, if_n.Da1, if_n.Rsv, if_n.RsvA, if_n.Re1, if_n.Re2} = drv[1];
  assign {if_z.We0, if_z.W0, if_z.Da0, if_z.We1, if_z.W1, if_z.Da1, if_z.Rsv, if_z.RsvA, if_z.Re1, if_z.Re2} = drv[2];

  always #5 Clk = ~Clk;

  function automatic drv_t mk(int we0, int w0, int da0, int we1, int w1, int da1,
                              int rsv, int rsva, int re1, int re2);
    drv_t r;
    r.we0 = (we0 != 0); r.w0 = 4'(w0); r.da0 = 16'(da0);
    r.we1 = (we1 != 0); r.w1 = 4'(w1); r.da1 = 16'(da1);
    r.rsv = (rsv != 0); r.rsva = 4'(rsva);
    r.re1 = 4'(re1); r.re2 = 4'(re2);
    return r;
  endfunction

  function automatic vec_t row(drv_t in, int d1, int p1, int d2, int p2);
    vec_t v;
    v.in = in; v.d1 = 16'(d1); v.p1 = (p1 != 0); v.d2 = 16'(d2); v.p2 = (p2 != 0);
    return v;
  endfunction

  function automatic logic [15:0] act_d(int inst, int port);
    case (inst)
      0:       return (port == 0) ? if_d.D1 : if_d.D2;
      1:       return (port == 0) ? if_n.D1 : if_n.D2;
      default: return (port == 0) ? if_z.D1 : if_z.D2;
    endcase
  endfunction

  function automatic logic act_p(int inst, int port);
    case (inst)
      0:       return (port == 0) ? if_d.P1 : if_d.P2;
      1:       return (port == 0) ? if_n.P1 : if_n.P2;
      default: return (port == 0) ? if_z.P1 : if_z.P2;
    endcase
  endfunction

  task automatic expect_rd(string name, int inst, int port, int d, int p);
    exp_t e;
    e.name = name; e.inst = inst; e.port = port; e.d = 16'(d); e.p = (p != 0);
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] ad;
    logic ap;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      ad = act_d(e.inst, e.port);
      ap = act_p(e.inst, e.port);
      n_chk++;
      if (ad !== e.d) begin
        n_fail++;
        $display("FAIL %s data: got %h expected %h", e.name, ad, e.d);
      end
      n_chk++;
      if (ap !== e.p) begin
        n_fail++;
        $display("FAIL %s pend: got %b expected %b", e.name, ap, e.p);
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Default instance: inputs held for one cycle, outputs observed before that cycle's edge.
    tbl[0]  = row(mk(0,0,0,       0,0,0,       0,0, 5,15), 'h5,    0, 'hF,    0);
    tbl[1]  = row(mk(1,3,'hAAAA,  1,3,'h5555,  0,0, 3, 3), 'h5555, 0, 'h5555, 0);
    tbl[2]  = row(mk(0,0,0,       0,0,0,       1,4, 3, 4), 'h5555, 0, 'h4,    0);
    tbl[3]  = row(mk(0,0,0,       0,0,0,       0,0, 4, 3), 'h4,    1, 'h5555, 0);
    tbl[4]  = row(mk(1,4,'h00FF,  0,0,0,       0,0, 4, 9), 'h00FF, 0, 'h9,    0);
    tbl[5]  = row(mk(0,0,0,       0,0,0,       0,0, 4, 3), 'h00FF, 0, 'h5555, 0);
    tbl[6]  = row(mk(0,0,0,       1,4,'h1111,  1,4, 4, 6), 'h1111, 0, 'h6,    0);
    tbl[7]  = row(mk(0,0,0,       0,0,0,       0,0, 4, 4), 'h1111, 1, 'h1111, 1);
    tbl[8]  = row(mk(0,0,0,       0,0,0,       1,4, 4, 0), 'h1111, 1, 'h0,    0);
    tbl[9]  = row(mk(1,7,'h7777,  0,0,0,       0,0, 4, 7), 'h1111, 1, 'h7777, 0);
    tbl[10] = row(mk(1,8,'hAAAA,  1,9,'hBBBB,  0,0, 8, 9), 'hAAAA, 0, 'hBBBB, 0);
    tbl[11] = row(mk(0,0,0,       0,0,0,       1,2, 8, 9), 'hAAAA, 0, 'hBBBB, 0);
    tbl[12] = row(mk(0,0,0,       0,0,0,       0,0, 2, 7), 'h2,    1, 'h7777, 0);
    tbl[13] = row(mk(1,4,'h2222,  0,0,0,       0,0, 4,15), 'h2222, 0, 'hF,    0);
    tbl[14] = row(mk(0,0,0,       0,0,0,       0,0, 4, 2), 'h2222, 0, 'h2,    1);

    for (int i = 0; i < 3; i++) drv[i] = '0;
    #1 Rst = 1'b0;
    drv[0].re1 = 4'd5; drv[0].re2 = 4'd15;
    drv[1].re1 = 4'd7;
    drv[2].re1 = 4'd5; drv[2].re2 = 4'd0;
    #1;
    expect_rd("reset d.A", 0, 0, 5, 0);
    expect_rd("reset d.B", 0, 1, 15, 0);
    expect_rd("reset n.A", 1, 0, 7, 0);
    expect_rd("reset z.A", 2, 0, 5, 0);
    expect_rd("reset z.B zero", 2, 1, 0, 0);
    drain();
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step();
      drv[0] = tbl[i].in;
      expect_rd($sformatf("r%0d.A", i), 0, 0, int'(tbl[i].d1), int'(tbl[i].p1));
      expect_rd($sformatf("r%0d.B", i), 0, 1, int'(tbl[i].d2), int'(tbl[i].p2));
      settle();
    end

    // No-bypass instance: writes only become visible after the edge.
    step(); drv[1] = mk(1,7,'h1234, 0,0,0, 0,0, 7,0); expect_rd("nb wr pre", 1, 0, 7, 0); settle();
    step(); drv[1] = mk(0,0,0, 0,0,0, 0,0, 7,0);       expect_rd("nb wr post", 1, 0, 'h1234, 0); settle();
    step(); drv[1] = mk(1,3,'hAAAA, 1,3,'h5555, 0,0, 3,0); expect_rd("nb coll pre", 1, 0, 3, 0); settle();
    step(); drv[1] = mk(0,0,0, 0,0,0, 0,0, 3,0);       expect_rd("nb coll post", 1, 0, 'h5555, 0); settle();
    step(); drv[1] = mk(0,0,0, 0,0,0, 1,5, 5,0);       expect_rd("nb rsv pre", 1, 0, 5, 0); settle();
    step(); drv[1] = mk(1,5,'h0055, 0,0,0, 0,0, 5,0);  expect_rd("nb pend vis", 1, 0, 5, 1); settle();
    step(); drv[1] = mk(0,0,0, 0,0,0, 0,0, 5,0);       expect_rd("nb wr clr", 1, 0, 'h0055, 0); settle();

    // Zero register and out-of-range addresses on the DEPTH=12 instance.
    step(); drv[2] = mk(1,0,'hFFFF, 1,13,'hDEAD, 1,0, 0,13);
    expect_rd("z r0 wr", 2, 0, 0, 0); expect_rd("z r13 wr", 2, 1, 0, 0); settle();
    step(); drv[2] = mk(0,0,0, 0,0,0, 1,13, 0,13);
    expect_rd("z r0 rd", 2, 0, 0, 0); expect_rd("z r13 rsv", 2, 1, 0, 0); settle();
    step(); drv[2] = mk(0,0,0, 1,11,'h0B0B, 0,0, 11,12);
    expect_rd("z r11 byp", 2, 0, 'h0B0B, 0); expect_rd("z r12", 2, 1, 0, 0); settle();
    for (int k = 0; k < 12; k++) begin
      step();
      drv[2] = mk(0,0,0, 0,0,0, 0,0, k, 12 + (k % 4));
      expect_rd($sformatf("z scan%0d", k), 2, 0, (k == 0) ? 0 : (k == 11) ? 'h0B0B : k, 0);
      expect_rd($sformatf("z oor%0d", 12 + (k % 4)), 2, 1, 0, 0);
      settle();
    end

    // Async reset in the middle of traffic on the default instance.
    step(); drv[0] = mk(1,2,'hBEEF, 0,0,0, 0,0, 2,4);
    expect_rd("mr wr byp", 0, 0, 'hBEEF, 0); expect_rd("mr r4", 0, 1, 'h2222, 0); settle();
    step(); drv[0] = mk(0,0,0, 0,0,0, 1,2, 2,3);
    expect_rd("mr rsv pre", 0, 0, 'hBEEF, 0); settle();
    step(); drv[0] = mk(0,0,0, 0,0,0, 0,0, 2,3);
    expect_rd("mr pend", 0, 0, 'hBEEF, 1); expect_rd("mr r3", 0, 1, 'h5555, 0); settle();
    #1 Rst = 1'b0;
    drv[1].re1 = 4'd5;
    #1;
    expect_rd("mr rst r2", 0, 0, 2, 0); expect_rd("mr rst r3", 0, 1, 3, 0);
    expect_rd("mr rst nb r5", 1, 0, 5, 0);
    drain();
    drv[0] = mk(1,6,'hDEAD, 1,6,'hCAFE, 1,6, 6,0);
    step();
    expect_rd("mr hold edge", 0, 0, 6, 0); settle();
    drv[0] = mk(0,0,0, 0,0,0, 0,0, 6,0);
    #1 Rst = 1'b1;
    step();
    expect_rd("mr after rel", 0, 0, 6, 0); settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
